// File: rtl/dct_fifo_pkg.sv
// dct_fifo_pkg
// Shared definitions for the DCT inter-stage FIFO:
//   - default word width and RAM depth
//   - level_width(): bits needed to count 0..DEPTH+1 words
//   - legality helpers used by the elaboration checks in fifo_level
package dct_fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 64;

    // Capacity is DEPTH words of RAM plus one in the output register.
    function automatic int level_width(input int depth);
        return $clog2(depth + 2);
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit levels_ok(input int ae, input int af, input int depth);
        return (ae < af) && (af <= depth + 1);
    endfunction

endpackage

// File: rtl/fifo_level_if.sv
// fifo_level_if
// Bundles the producer side (i_*), consumer side (o_*), flush and status
// flags of fifo_level.
//   slave  : the FIFO itself
//   master : the environment driving writes, acks and flush
interface fifo_level_if #(
    parameter int WIDTH = dct_fifo_pkg::DEFAULT_WIDTH,
    parameter int DEPTH = dct_fifo_pkg::DEFAULT_DEPTH
);
    localparam int LW = dct_fifo_pkg::level_width(DEPTH);

    logic             i_flush;
    logic [WIDTH-1:0] i_data;
    logic             i_stb;
    logic             i_ack;
    logic [WIDTH-1:0] o_data;
    logic             o_stb;
    logic             o_ack;
    logic [LW-1:0]    o_level;
    logic             o_full;
    logic             o_empty;
    logic             o_afull;
    logic             o_aempty;
    logic             o_ovf;

    modport slave (
        input  i_flush, i_data, i_stb, o_ack,
        output i_ack, o_data, o_stb, o_level, o_full, o_empty, o_afull, o_aempty, o_ovf
    );

    modport master (
        output i_flush, i_data, i_stb, o_ack,
        input  i_ack, o_data, o_stb, o_level, o_full, o_empty, o_afull, o_aempty, o_ovf
    );
endinterface

// File: rtl/fifo_ram.sv
// fifo_ram
// Simple dual-port RAM, WIDTH x DEPTH, written synchronously and read through
// an enabled output register so it maps onto block RAM with its output reg.
//   clk, rst          : clock, asynchronous reset (output register only)
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr     : read port; rd_data updates on the edge where rd_en=1
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Holds the last word when not enabled: the consumer keeps seeing it.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/fifo_level.sv
// fifo_level
// Synchronous FIFO with strobe/ack handshake on both sides, a full-depth RAM
// plus one registered output word, occupancy count, programmable
// almost-full/almost-empty flags, synchronous flush and sticky overflow.
//   CLK  : clock, rising edge
//   RST  : asynchronous active-high reset
//   bus  : fifo_level_if.slave -- i_data/i_stb/i_ack write side,
//          o_data/o_stb/o_ack read side, i_flush, o_level and status flags
module fifo_level
    import dct_fifo_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic         CLK,
    input  logic         RST,
    fifo_level_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = level_width(DEPTH);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("fifo_level: DEPTH must be a power of two >= 2");
    end
    if (!levels_ok(AE_LEVEL, AF_LEVEL, DEPTH)) begin : g_bad_levels
        $error("fifo_level: need AE_LEVEL < AF_LEVEL <= DEPTH+1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("fifo_level: WIDTH must be >= 1");
    end

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          o_stb_q, o_stb_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] ram_cnt;
    logic          ram_full;
    logic          wr_en;
    logic          ld;
    logic [LW-1:0] level;

    always_comb begin
        // One extra pointer bit distinguishes full from empty, so every
        // RAM entry is usable.
        ram_cnt  = wptr_q - rptr_q;
        ram_full = (ram_cnt == PW'(DEPTH));
        // Gated by RST so nothing looks accepted while state is held in reset.
        wr_en    = bus.i_stb & ~ram_full & ~bus.i_flush & ~RST;
        // Refill the output register when it is empty or being taken now.
        ld       = (ram_cnt != '0) & (~o_stb_q | bus.o_ack) & ~bus.i_flush;
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        o_stb_d = o_stb_q;
        ovf_d   = ovf_q;
        if (bus.i_flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            o_stb_d = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            if (wr_en) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (ld) begin
                rptr_d  = rptr_q + PW'(1);
                o_stb_d = 1'b1;
            end else if (o_stb_q & bus.o_ack) begin
                o_stb_d = 1'b0;
            end
            if (bus.i_stb & ram_full) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            o_stb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            o_stb_q <= o_stb_d;
            ovf_q   <= ovf_d;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (CLK),
        .rst     (RST),
        .wr_en   (wr_en),
        .wr_addr (wptr_q[AW-1:0]),
        .wr_data (bus.i_data),
        .rd_en   (ld),
        .rd_addr (rptr_q[AW-1:0]),
        .rd_data (bus.o_data)
    );

    // Status is decoded from registered state only.
    assign level        = LW'(ram_cnt) + LW'(o_stb_q);
    assign bus.i_ack    = wr_en;
    assign bus.o_stb    = o_stb_q;
    assign bus.o_level  = level;
    assign bus.o_full   = ram_full;
    assign bus.o_empty  = (level == '0);
    assign bus.o_afull  = (level >= LW'(AF_LEVEL));
    assign bus.o_aempty = (level <= LW'(AE_LEVEL));
    assign bus.o_ovf    = ovf_q;
endmodule

// File: tb/tb_fifo_level.sv
module tb_fifo_level;
    localparam int WIDTH = 8;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fifo_level_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    fifo_level #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (60),
        .AE_LEVEL (4)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] sb[$];
    logic [7:0] exp_word;
    int         idx;
    int         sent;
    int         recv;
    int         lvl;

    initial begin
        bus.i_flush = 1'b0;
        bus.i_data  = 8'h77;
        bus.i_stb   = 1'b1;
        bus.o_ack   = 1'b0;

        // Reset state (i_stb high must not be acknowledged in reset)
        @(negedge clk); #1;
        check("rst_o_stb",  bus.o_stb,    0);
        check("rst_o_data", bus.o_data,   0);
        check("rst_level",  bus.o_level,  0);
        check("rst_empty",  bus.o_empty,  1);
        check("rst_full",   bus.o_full,   0);
        check("rst_afull",  bus.o_afull,  0);
        check("rst_aempty", bus.o_aempty, 1);
        check("rst_ovf",    bus.o_ovf,    0);
        check("rst_i_ack",  bus.i_ack,    0);
        bus.i_stb = 1'b0;
        @(negedge clk); rst = 1'b0;

        // Single word: accepted in cycle 0, visible in cycle 2
        @(negedge clk); bus.i_stb = 1'b1; bus.i_data = 8'hA5; #1;
        check("sw_ack_c0",   bus.i_ack,   1);
        check("sw_level_c0", bus.o_level, 0);
        @(negedge clk); bus.i_stb = 1'b0; #1;
        check("sw_stb_c1",    bus.o_stb,    0);
        check("sw_level_c1",  bus.o_level,  1);
        check("sw_empty_c1",  bus.o_empty,  0);
        check("sw_aempty_c1", bus.o_aempty, 1);
        @(negedge clk); #1;
        check("sw_stb_c2",   bus.o_stb,   1);
        check("sw_data_c2",  bus.o_data,  8'hA5);
        check("sw_level_c2", bus.o_level, 1);
        @(negedge clk); bus.o_ack = 1'b1; #1;
        @(negedge clk); bus.o_ack = 1'b0; #1;
        check("sw_stb_done",  bus.o_stb,   0);
        check("sw_level_done", bus.o_level, 0);
        check("sw_data_hold", bus.o_data,  8'hA5);

        // Fill: 70 strobes, no reads; 65 accepted
        for (int k = 0; k < 70; k++) begin
            @(negedge clk); bus.i_stb = 1'b1; bus.i_data = 8'(k); #1;
            lvl = (k < 65) ? k : 65;
            check($sformatf("fill_ack_%0d", k),   bus.i_ack,   (k < 65) ? 1 : 0);
            check($sformatf("fill_lvl_%0d", k),   bus.o_level, lvl);
            check($sformatf("fill_af_%0d", k),    bus.o_afull, (lvl >= 60) ? 1 : 0);
            check($sformatf("fill_ae_%0d", k),    bus.o_aempty, (lvl <= 4) ? 1 : 0);
            check($sformatf("fill_full_%0d", k),  bus.o_full,  (k >= 65) ? 1 : 0);
            check($sformatf("fill_ovf_%0d", k),   bus.o_ovf,   (k >= 66) ? 1 : 0);
        end
        check("fill_head_stb",  bus.o_stb,  1);
        check("fill_head_data", bus.o_data, 0);

        // Full plus one read: slot frees only on the following cycle
        @(negedge clk); bus.i_stb = 1'b1; bus.i_data = 8'hC8; bus.o_ack = 1'b1; #1;
        check("fr_ack_same", bus.i_ack,   0);
        check("fr_level",    bus.o_level, 65);
        check("fr_data0",    bus.o_data,  0);
        @(negedge clk); bus.o_ack = 1'b0; #1;
        check("fr_ack_next", bus.i_ack,   1);
        check("fr_data1",    bus.o_data,  1);
        check("fr_level64",  bus.o_level, 64);
        @(negedge clk); bus.i_stb = 1'b0; #1;
        check("fr_level65",  bus.o_level, 65);
        check("fr_full",     bus.o_full,  1);

        // Drain: 1..64 then the late word 0xC8
        idx = 0;
        for (int c = 0; c < 200 && idx < 65; c++) begin
            @(negedge clk); bus.o_ack = 1'b1; #1;
            if (bus.o_stb) begin
                exp_word = (idx < 64) ? 8'(idx + 1) : 8'hC8;
                check($sformatf("drain_%0d", idx), bus.o_data, exp_word);
                idx++;
            end
        end
        check("drain_count", idx, 65);
        @(negedge clk); bus.o_ack = 1'b0; #1;
        check("drain_empty", bus.o_empty, 1);
        check("drain_level", bus.o_level, 0);

        // Streaming 500 words with ~30% consumer stalls
        sent = 0; recv = 0;
        for (int c = 0; c < 5000 && recv < 500; c++) begin
            @(negedge clk);
            bus.i_stb  = (sent < 500);
            bus.i_data = 8'(sent * 7 + 3);
            bus.o_ack  = ($urandom_range(0, 99) >= 30);
            #1;
            if (bus.o_level > 65) check("stream_level_max", bus.o_level, 65);
            if (bus.o_stb && bus.o_ack) begin
                if (sb.size() == 0) begin
                    check("stream_spurious", bus.o_data, 0);
                    recv++;
                end else begin
                    exp_word = sb.pop_front();
                    check($sformatf("stream_%0d", recv), bus.o_data, exp_word);
                    recv++;
                end
            end
            if (bus.i_stb && bus.i_ack) begin
                sb.push_back(bus.i_data);
                sent++;
            end
        end
        check("stream_recv", recv, 500);
        @(negedge clk); bus.i_stb = 1'b0; bus.o_ack = 1'b0; #1;
        check("stream_empty", bus.o_empty, 1);

        // Flush with 10 words buffered and a transfer in the same cycle
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); bus.i_stb = 1'b1; bus.i_data = 8'(8'h10 + k); #1;
            check($sformatf("fl_wr_%0d", k), bus.i_ack, 1);
        end
        @(negedge clk); bus.i_stb = 1'b0; #1;
        @(negedge clk); #1;
        check("fl_pre_level", bus.o_level, 10);
        check("fl_pre_ovf",   bus.o_ovf,   1);
        @(negedge clk); bus.i_flush = 1'b1; bus.i_stb = 1'b1; bus.i_data = 8'hEE; bus.o_ack = 1'b1; #1;
        check("fl_ack",       bus.i_ack,  0);
        check("fl_head_stb",  bus.o_stb,  1);
        check("fl_head_data", bus.o_data, 8'h10);
        @(negedge clk); bus.i_flush = 1'b0; bus.o_ack = 1'b0; bus.i_data = 8'h3C; #1;
        check("fl_level", bus.o_level, 0);
        check("fl_empty", bus.o_empty, 1);
        check("fl_ovf",   bus.o_ovf,   0);
        check("fl_stb",   bus.o_stb,   0);
        check("fl_wr_ack", bus.i_ack,  1);
        @(negedge clk); bus.i_stb = 1'b0; #1;
        check("fl_next_stb1", bus.o_stb,   0);
        check("fl_next_lvl1", bus.o_level, 1);
        @(negedge clk); #1;
        check("fl_next_stb2",  bus.o_stb,  1);
        check("fl_next_data2", bus.o_data, 8'h3C);
        @(negedge clk); bus.o_ack = 1'b1; #1;
        @(negedge clk); bus.o_ack = 1'b0; #1;
        check("fl_final_empty", bus.o_empty, 1);

        // Async reset with 20 words buffered
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); bus.i_stb = 1'b1; bus.i_data = 8'(8'h40 + k); #1;
        end
        @(negedge clk); bus.i_stb = 1'b0; #1;
        @(negedge clk); #1;
        check("ar_pre_level", bus.o_level, 20);
        check("ar_pre_data",  bus.o_data,  8'h40);
        #1 rst = 1'b1;
        #1;
        check("ar_stb",    bus.o_stb,    0);
        check("ar_level",  bus.o_level,  0);
        check("ar_data",   bus.o_data,   0);
        check("ar_empty",  bus.o_empty,  1);
        check("ar_aempty", bus.o_aempty, 1);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); bus.i_stb = 1'b1; bus.i_data = 8'h5A; #1;
        check("ar_resume_ack", bus.i_ack,   1);
        check("ar_resume_lvl0", bus.o_level, 0);
        @(negedge clk); bus.i_stb = 1'b0; #1;
        check("ar_resume_stb1", bus.o_stb, 0);
        @(negedge clk); #1;
        check("ar_resume_stb2",  bus.o_stb,   1);
        check("ar_resume_data2", bus.o_data,  8'h5A);
        check("ar_resume_lvl2",  bus.o_level, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_level.md
# fifo_level

Parametrised synchronous FIFO with strobe/acknowledge handshake on both sides, a full-depth RAM, a registered output stage, an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush and a sticky overflow flag. It sits between DCT pipeline stages where a producer needs back-pressure warning before the buffer fills and the controller must discard a partial block without a reset.

## Interface
- WIDTH, 8: data word width in bits, ≥1.
- DEPTH, 64: RAM entries, power of two, ≥2. Total capacity is DEPTH+1 words: DEPTH in RAM plus 1 in the output register.
- AF_LEVEL, DEPTH-4: o_afull asserts when o_level ≥ AF_LEVEL.
- AE_LEVEL, 4: o_aempty asserts when o_level ≤ AE_LEVEL. Constraint: AE_LEVEL < AF_LEVEL ≤ DEPTH+1.
- Derived: LW = $clog2(DEPTH+2).

Ports:
- CLK  in  1  clock, all logic on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- i_flush  in  1  synchronous discard of all contents.
- i_data  in  WIDTH  write data.
- i_stb  in  1  write request.
- i_ack  out  1  write accepted this cycle.
- o_data  out  WIDTH  read data, registered.
- o_stb  out  1  o_data valid, registered.
- o_ack  in  1  consumer takes o_data.
- o_level  out  LW  words held, 0..DEPTH+1.
- o_full, o_empty, o_afull, o_aempty  out  1  status flags.
- o_ovf  out  1  sticky overflow.

## Operation
- Pointers wptr/rptr are $clog2(DEPTH)+1 bits. ram_cnt = wptr−rptr (modulo), ram_full = (ram_cnt == DEPTH). All DEPTH entries are usable, with no spare-slot scheme. Wrap-around is by natural pointer overflow.
- Write: i_ack = i_stb & !ram_full & !i_flush, combinational. On i_ack, write RAM[wptr] and increment wptr.
- Load: ld = (ram_cnt≠0) & (!o_stb | o_ack) & !i_flush. On ld, o_data ← RAM[rptr], increment rptr, o_stb ← 1.
- Drain: when o_stb & o_ack & !ld, o_stb ← 0. o_data holds its value.
- Transfer on the output side happens when o_stb & o_ack. o_ack with o_stb=0 is ignored.
- o_level = ram_cnt + o_stb. o_full = ram_full. o_empty = (o_level==0). Flags are driven from registers only, with no path from i_stb or o_ack.
- o_ovf is set when i_stb & ram_full & !i_flush, and is cleared only by i_flush or RST.
- Flush: at the edge with i_flush=1, wptr=rptr=0, o_stb=0, o_ovf=0; RAM contents are don't-care. A simultaneous o_stb&o_ack still counts as a completed transfer for the consumer. No write is accepted in the flush cycle.
- Reset values: o_stb=0, o_data=0, o_level=0, o_empty=1, o_full=0, o_afull=0, o_aempty=1, o_ovf=0, i_ack=0. RST mid-operation loses all contents immediately.

## Timing
- Write-to-read latency: a word accepted in cycle c, with the FIFO empty, appears with o_stb=1 in cycle c+2.
- Throughput is one word per cycle in and out at the same time, once primed.
- A read does not free a write slot in the same cycle. With ram_full, i_ack stays 0 even if o_ack=1, and becomes 1 the next cycle.
- There is no bypass: a write into an empty RAM is never forwarded to o_data in the same cycle.
- o_level updates one edge after each accept or transfer. It reads DEPTH+1 when both RAM and the output register are full.

## Structure
- Shared package dct_fifo_pkg holds a level-width function (clog2(depth+2)), default WIDTH/DEPTH constants, and parameter-legality checks (power-of-two DEPTH, threshold ordering) used by elaboration asserts.
- Sub-module fifo_ram is a simple dual-port RAM, WIDTH×DEPTH, with synchronous write and synchronous read-enable port feeding o_data, for block-RAM inference.
- The top level holds pointers, handshake, flags and flush.

## Test plan
- Reset then single word: RST pulse, write 0xA5 in cycle 0. Required: o_stb=1 with o_data=0xA5 in cycle 2; o_level 0→1; o_empty drops; o_aempty stays 1.
- Fill with DEPTH=64, o_ack=0, i_stb held for 70 cycles with data 0..69. Required: 65 accepts (0..64); o_full=1; o_level=65; o_afull=1 once o_level reaches 60; o_ovf=1 after the first rejected strobe.
- Full plus read: from the full state, pulse o_ack once. Required: i_ack=0 that cycle and 1 the next; o_data sequence continues 0,1,…; no word lost or duplicated.
- Streaming: i_stb and o_ack held high for 500 words across several wraps, with random o_ack stalls of 30%. Required: output equals input order exactly, and o_level never exceeds 65.
- Flush: 10 words buffered, o_stb=1, o_ack=1, i_stb=1 in the flush cycle. Required: head word counted as delivered; i_ack=0; next cycle o_level=0, o_empty=1, o_ovf=0; the next write appears 2 cycles later.
- Async reset mid-stream: RST asserted between edges with 20 words buffered. Required: o_stb=0, o_level=0 and o_data=0 immediately without a clock; resumes cleanly after release.
